alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 3-bit-opcode ALU.
- Keeps the same eight operations and adds:
  - configurable data width;
  - an internal accumulator that can replace operand A and capture results;
  - status flags;
  - valid/ready handshakes on both sides.
- Sits between the datapath sequencer and the register file.
- One result per cycle when the output is not stalled.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 4).
- ACC_RESET, 0, accumulator value after reset or acc_clr (WIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present on op_code/a/b/acc_sel/acc_we.
- in_ready  output  1  block can accept a request this cycle.
- op_code  input  3  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- acc_sel  input  1  1 = use accumulator in place of a.
- acc_we  input  1  1 = write result into accumulator on acceptance.
- acc_clr  input  1  synchronous accumulator clear to ACC_RESET.
- out_valid  output  1  y and flags hold a result.
- out_ready  input  1  consumer takes result this cycle.
- y  output  WIDTH  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result MSB.
- flag_c  output  1  carry (add/inc) or borrow (sub/dec).
- flag_v  output  1  signed overflow.
- acc  output  WIDTH  current accumulator value.

Behaviour:
- Reset (async assert, any time, including mid-stall):
  - out_valid=0, y=0, all flags=0, acc=ACC_RESET.
  - Any pending result is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Latency: exactly 1 cycle from acceptance edge to out_valid=1.
  - Back-to-back issue allowed: one result per cycle while out_ready=1.
- Output register hold:
  - If out_valid && !out_ready, y, flags and out_valid hold unchanged.
  - No request is accepted while holding.
  - The block never drops or duplicates a result.
- out_valid update on each edge:
  - Accept → 1.
  - Else if out_ready → 0.
  - Else hold.
- Operand selection: OA = acc_sel ? acc : a. The acc value used is the one before this edge's update.
- Operations, all modulo 2^WIDTH:
  - 000 Y=OA
  - 001 Y=OA+B
  - 010 Y=OA−B
  - 011 Y=OA&B
  - 100 Y=OA|B
  - 101 Y=OA+1
  - 110 Y=OA−1
  - 111 Y=B
- flag_c:
  - Add/inc: carry-out of the WIDTH+1-bit sum.
  - Sub/dec: 1 when OA < subtrahend, unsigned.
  - All other ops: 0.
- flag_v:
  - Add/inc: operands have the same sign and the result sign differs.
  - Sub/dec: operands have different signs and the result sign differs from OA.
  - All other ops: 0.
- flag_z and flag_n are computed from Y for every op.
- Accumulator:
  - On acceptance with acc_we=1, acc ← Y at the same edge the result register loads.
  - The next accepted acc_sel op therefore sees the updated value; no bubble is required.
  - acc_clr (sampled every edge, independent of handshake) forces acc=ACC_RESET.
  - acc_clr overrides a simultaneous acc_we write. The result register still loads Y normally.
- Requests with in_valid=0: acc_we and acc_sel are ignored and there is no state change.

Test Plan:
- Reset and idle, WIDTH=8: assert reset mid-stream with out_valid=1 → out_valid=0, y=0x00, flags=0, acc=0x00 immediately (async). in_ready=1 after reset.
- Op sweep: a=0x0F, b=0x03, op 000..111 with out_ready=1 → one cycle after each acceptance, y = 0x0F, 0x12, 0x0C, 0x03, 0x0F, 0x10, 0x0E, 0x03.
- Flags, WIDTH=8:
  - add 0x7F+0x01 → y=0x80, n=1, v=1, c=0.
  - add 0xFF+0x01 → y=0x00, z=1, c=1, v=0.
  - sub 0x00−0x01 → y=0xFF, c=1, n=1.
  - dec 0x80 → y=0x7F, v=1.
- Accumulator chain: acc_clr, then four back-to-back add requests, b=5, acc_sel=1, acc_we=1 → y sequence 5, 10, 15, 20 on consecutive cycles; acc=20.
- Clear priority: acc_clr=1 in the same cycle as an accepted acc_we add → acc=ACC_RESET; y still shows the add result.
- Backpressure: issue 3 requests with out_ready held 0 for 4 cycles:
  - First result holds stable; in_ready=0; requests 2 and 3 wait.
  - Release out_ready → results appear in order, with no loss or duplication.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered 8-operation ALU with a valid/ready handshake, status flags and an accumulator.
// An accepted result loads the output register and, optionally, the accumulator on the same edge.
module alu_pipe #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_sel,
  input  logic             acc_we,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] acc
);

  logic [WIDTH-1:0] oa;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] y_next;
  logic             c_next;
  logic             v_next;
  logic             accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    oa     = acc_sel ? acc : a;
    // inc/dec reuse the add/sub paths with a constant second operand
    opnd   = (op_code == 3'b101 || op_code == 3'b110) ? WIDTH'(1) : b;
    sum    = {1'b0, oa} + {1'b0, opnd};
    diff   = {1'b0, oa} - {1'b0, opnd};
    y_next = '0;
    c_next = 1'b0;
    v_next = 1'b0;
    case (op_code)
      3'b000: y_next = oa;
      3'b001, 3'b101: begin
        y_next = sum[WIDTH-1:0];
        c_next = sum[WIDTH];
        v_next = (oa[WIDTH-1] == opnd[WIDTH-1]) && (sum[WIDTH-1] != oa[WIDTH-1]);
      end
      3'b010, 3'b110: begin
        y_next = diff[WIDTH-1:0];
        c_next = diff[WIDTH];
        v_next = (oa[WIDTH-1] != opnd[WIDTH-1]) && (diff[WIDTH-1] != oa[WIDTH-1]);
      end
      3'b011: y_next = oa & b;
      3'b100: y_next = oa | b;
      default: y_next = b;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= y_next;
      flag_z    <= (y_next == '0);
      flag_n    <= y_next[WIDTH-1];
      flag_c    <= c_next;
      flag_v    <= v_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // clear wins over a simultaneous accumulator write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 acc <= ACC_RESET;
    else if (acc_clr)          acc <= ACC_RESET;
    else if (accept && acc_we) acc <= y_next;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=8: vector table for ops/flags, plus
// sequences for accumulator chaining, clear priority, backpressure and async reset.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [2:0]   op_code;
  logic [W-1:0] a, b;
  logic         acc_sel, acc_we, acc_clr;
  logic         out_valid, out_ready;
  logic [W-1:0] y, acc;
  logic         flag_z, flag_n, flag_c, flag_v;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(W), .ACC_RESET(8'h00)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .a(a), .b(b),
    .acc_sel(acc_sel), .acc_we(acc_we), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .acc(acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         z, n, c, v;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // op sweep, a=0x0F b=0x03
    vecs[0]  = '{3'b000, 8'h0F, 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b001, 8'h0F, 8'h03, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 8'h0F, 8'h03, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b011, 8'h0F, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 8'h0F, 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b101, 8'h0F, 8'h03, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 8'h0F, 8'h03, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 8'h0F, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    // flag corners
    vecs[8]  = '{3'b001, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b010, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'b110, 8'h80, 8'h55, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; op_code = 3'b000; a = '0; b = '0;
    acc_sel = 1'b0; acc_we = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_y", 32'(y), 32'h0);
    check("reset_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
    check("reset_acc", 32'(acc), 32'h0);
    check("reset_in_ready", 32'(in_ready), 32'h1);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; op_code = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      step();
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
      check($sformatf("vec%0d_zncv", i), 32'({flag_z, flag_n, flag_c, flag_v}),
            32'({vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v}));
    end
    in_valid = 1'b0;
    step();
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // accumulator chain
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("chain_acc_cleared", 32'(acc), 32'h0);
    in_valid = 1'b1; op_code = 3'b001; a = 8'h77; b = 8'd5; acc_sel = 1'b1; acc_we = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("chain%0d_y", k), 32'(y), 32'(5 * k));
      check($sformatf("chain%0d_valid", k), 32'(out_valid), 32'h1);
    end
    check("chain_acc", 32'(acc), 32'd20);

    // clear priority over a simultaneous acc_we add
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    check("clrprio_y", 32'(y), 32'h19);
    check("clrprio_acc", 32'(acc), 32'h0);
    in_valid = 1'b0; acc_sel = 1'b0; acc_we = 1'b0;
    step();

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; op_code = 3'b000; a = 8'h01;
    step();
    check("bp_first_y", 32'(y), 32'h01);
    a = 8'h02;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("bp_hold%0d_y", k), 32'(y), 32'h01);
      check($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    step();
    check("bp_second_y", 32'(y), 32'h02);
    a = 8'h03;
    step();
    check("bp_third_y", 32'(y), 32'h03);
    check("bp_third_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    step();
    check("bp_drained", 32'(out_valid), 32'h0);
    check("bp_acc_untouched", 32'(acc), 32'h0);

    // async reset mid-stall
    out_ready = 1'b0;
    in_valid = 1'b1; op_code = 3'b001; a = 8'h50; b = 8'h05; acc_we = 1'b1;
    step();
    in_valid = 1'b0; acc_we = 1'b0;
    check("stall_y", 32'(y), 32'h55);
    check("stall_acc", 32'(acc), 32'h55);
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'h0);
    check("midreset_y", 32'(y), 32'h0);
    check("midreset_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
    check("midreset_acc", 32'(acc), 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'h1);
    #3;
    reset = 1'b0;
    step();
    check("post_reset_out_valid", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
